// File: rtl/shared_bus_pkg.sv
// Shared definitions for the round-robin shared-bus arbiter.
package shared_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 64;
   localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at index >= rr_ptr,
// wrapping to the lowest requester when none exists at or above the pointer.
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic                       any,
   output logic [$clog2(NUM_REQ)-1:0] sel
);
   localparam int SW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] at_or_above;
   logic [NUM_REQ-1:0] masked;
   logic [SW-1:0]      sel_hi;
   logic [SW-1:0]      sel_lo;

   // Mark the requester slots that sit at or above the round-robin pointer.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign at_or_above[gi] = (SW'(gi) >= rr_ptr);
   end

   assign masked = req & at_or_above;
   assign any    = |req;

   // Lowest set bit among requesters at or above the pointer.
   always_comb begin
      sel_hi = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (masked[i]) begin
            sel_hi = SW'(i);
         end
      end
   end

   // Lowest set bit overall, used when the search wraps past the top index.
   always_comb begin
      sel_lo = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_lo = SW'(i);
         end
      end
   end

   assign sel = (|masked) ? sel_hi : sel_lo;

endmodule

// File: rtl/shared_bus_arbiter.sv
// N-way round-robin arbiter and registered bus multiplexer with burst limiting.
module shared_bus_arbiter
   import shared_bus_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [DATA_W-1:0]           sharedBus,
   output logic                        bus_valid,
   output logic [$clog2(NUM_REQ)-1:0]  bus_owner,
   output logic                        busy
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   // Counter value before the capture that completes the final allowed beat.
   localparam logic [CW-1:0]      LAST_BEAT = CW'(MAX_BURST - 1);
   localparam logic [OW-1:0]      LAST_IDX  = OW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

   arb_state_t        state_reg;
   logic [OW-1:0]     rr_ptr_reg;
   logic [CW-1:0]     burst_cnt_reg;

   logic              pick_any;
   logic [OW-1:0]     pick_sel;
   logic [DATA_W-1:0] data_slice [NUM_REQ];
   logic [DATA_W-1:0] owner_data;

   // Unpack the flattened payload bus into one word per requester.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_slice[gi] = data[gi*DATA_W +: DATA_W];
   end

   assign owner_data = data_slice[bus_owner];
   assign busy       = (state_reg != IDLE);

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_reg),
      .any    (pick_any),
      .sel    (pick_sel)
   );

   // Arbitration FSM, burst counter and bus register; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         burst_cnt_reg <= '0;
         gnt           <= '0;
         sharedBus     <= '0;
         bus_valid     <= 1'b0;
         bus_owner     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               bus_valid <= 1'b0;
               if (pick_any) begin
                  gnt           <= ONE_HOT_0 << pick_sel;
                  bus_owner     <= pick_sel;
                  burst_cnt_reg <= '0;
                  state_reg     <= GRANT;
               end
            end
            GRANT: begin
               if (!req[bus_owner]) begin
                  // Owner withdrew: release without capturing a beat.
                  gnt       <= '0;
                  bus_valid <= 1'b0;
                  state_reg <= TURN;
               end else begin
                  sharedBus     <= owner_data;
                  bus_valid     <= 1'b1;
                  burst_cnt_reg <= burst_cnt_reg + CW'(1);
                  if (burst_cnt_reg == LAST_BEAT) begin
                     // Final allowed beat: force release on the same edge.
                     gnt       <= '0;
                     state_reg <= TURN;
                  end
               end
            end
            TURN: begin
               bus_valid  <= 1'b0;
               rr_ptr_reg <= (bus_owner == LAST_IDX) ? '0 : bus_owner + OW'(1);
               state_reg  <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
